// File: rtl/sdram_pkg.sv
// SDRAM command encodings, error codes and mode-register fields,
// shared by the responder and the memory controller.
package sdram_pkg;

  typedef enum logic [3:0] {
    CMD_LMR = 4'b0000,
    CMD_REF = 4'b0001,
    CMD_PRE = 4'b0010,
    CMD_ACT = 4'b0011,
    CMD_WR  = 4'b0100,
    CMD_RD  = 4'b0101,
    CMD_BST = 4'b0110,
    CMD_NOP = 4'b0111,
    CMD_INH = 4'b1111
  } sdram_cmd_e;

  typedef enum logic [3:0] {
    ERR_NONE        = 4'd0,
    ERR_NO_MODE     = 4'd1,
    ERR_BANK_OPEN   = 4'd2,
    ERR_BANK_CLOSED = 4'd3,
    ERR_TRCD        = 4'd4,
    ERR_REF_OPEN    = 4'd5,
    ERR_TRC         = 4'd6,
    ERR_MODE        = 4'd7,
    ERR_CONTEND     = 4'd8
  } sdram_err_e;

  localparam int MODE_CL_MSB = 6;
  localparam int MODE_CL_LSB = 4;
  localparam int MODE_BL_MSB = 2;
  localparam int MODE_BL_LSB = 0;
  localparam int A_AUTO_PRE  = 10;

  typedef struct packed {
    logic        open;
    logic [12:0] row;
    logic [3:0]  stamp;
  } bank_t;

  function automatic sdram_cmd_e decode_cmd(
    input logic cke,
    input logic ncs,
    input logic nras,
    input logic ncas,
    input logic nwe
  );
    if (!cke || ncs) return CMD_INH;
    return sdram_cmd_e'({1'b0, nras, ncas, nwe});
  endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// Backing store for the SDRAM responder: single-port,
// byte-enabled writes, one-cycle registered read.
module sdram_resp_mem #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [1:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] ram [2**AW];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        if (be[0]) ram[addr][7:0]  <= wdata[7:0];
        if (be[1]) ram[addr][15:8] <= wdata[15:8];
      end else begin
        rdata <= ram[addr];
      end
    end
  end

endmodule

// File: rtl/sdram_responder.sv
// Pin-level model of one 16-bit SDR SDRAM: command decode,
// bank/timing tracking, CAS-latency read pipe, protocol checks.
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int MEM_AW = 14,
  parameter int TRCD   = 2,
  parameter int TRC    = 7
) (
  input  logic        clk,
  input  logic        init_n,
  inout  wire  [15:0] SDRAM_DQ,
  input  logic [12:0] SDRAM_A,
  input  logic [1:0]  SDRAM_BA,
  input  logic        SDRAM_DQML,
  input  logic        SDRAM_DQMH,
  input  logic        SDRAM_nCS,
  input  logic        SDRAM_nRAS,
  input  logic        SDRAM_nCAS,
  input  logic        SDRAM_nWE,
  input  logic        SDRAM_CKE,
  output logic        mode_valid,
  output logic [1:0]  cas_lat,
  output logic [15:0] refresh_cnt,
  output logic        proto_err,
  output logic [3:0]  err_code
);

  localparam logic [3:0] TRCD_V = 4'(TRCD);
  localparam logic [7:0] TRC_V  = 8'(TRC);

  sdram_cmd_e cmd;
  sdram_err_e err_now;
  sdram_err_e err_q;
  bank_t      banks [4];
  bank_t      cur;

  logic [7:0]  ref_age;
  logic        mode_q;
  logic [1:0]  cl_q;
  logic [15:0] ref_cnt_q;
  logic        err_q_flag;

  logic        rd_pend;
  logic [1:0]  pv;
  logic [15:0] pd [2];
  logic [15:0] rdata;

  logic is_act, is_rd, is_wr, is_acc;
  logic any_open, non_nop, mode_sup;
  logic rd_busy, drv;
  logic [15:0] dout;
  logic mem_en;
  logic [MEM_AW-1:0] mem_addr;

  assign cmd = decode_cmd(SDRAM_CKE, SDRAM_nCS,
                          SDRAM_nRAS, SDRAM_nCAS,
                          SDRAM_nWE);
  assign cur = banks[SDRAM_BA];

  assign is_act   = (cmd == CMD_ACT);
  assign is_rd    = (cmd == CMD_RD);
  assign is_wr    = (cmd == CMD_WR);
  assign is_acc   = is_rd | is_wr;
  assign non_nop  = (cmd != CMD_NOP) && (cmd != CMD_INH);
  assign any_open = banks[0].open | banks[1].open
                  | banks[2].open | banks[3].open;

  assign mode_sup =
    ((SDRAM_A[MODE_CL_MSB:MODE_CL_LSB] == 3'd2) ||
     (SDRAM_A[MODE_CL_MSB:MODE_CL_LSB] == 3'd3)) &&
    (SDRAM_A[MODE_BL_MSB:MODE_BL_LSB] == 3'd0);

  // Bus is busy from the READ edge until the data cycle ends.
  assign rd_busy = rd_pend | pv[0]
                 | ((cl_q == 2'd3) & pv[1]);

  always_comb begin
    err_now = ERR_NONE;
    if ((is_act | is_acc) & !mode_q)
      err_now = ERR_NO_MODE;
    else if (is_act & cur.open)
      err_now = ERR_BANK_OPEN;
    else if (is_acc & !cur.open)
      err_now = ERR_BANK_CLOSED;
    else if (is_acc & (cur.stamp < TRCD_V))
      err_now = ERR_TRCD;
    else if ((cmd == CMD_REF) & any_open)
      err_now = ERR_REF_OPEN;
    else if (non_nop & (ref_age < TRC_V))
      err_now = ERR_TRC;
    else if ((cmd == CMD_LMR) & !mode_sup)
      err_now = ERR_MODE;
    else if (is_wr & rd_busy)
      err_now = ERR_CONTEND;
  end

  assign mem_en   = is_acc & cur.open;
  assign mem_addr = MEM_AW'({SDRAM_BA, cur.row,
                             SDRAM_A[8:0]});

  sdram_resp_mem #(.AW(MEM_AW)) u_mem (
    .clk   (clk),
    .en    (mem_en),
    .we    (is_wr),
    .be    ({~SDRAM_DQMH, ~SDRAM_DQML}),
    .addr  (mem_addr),
    .wdata (SDRAM_DQ),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!init_n) begin
      for (int i = 0; i < 4; i++) banks[i] <= '0;
      ref_age    <= TRC_V;
      mode_q     <= 1'b0;
      cl_q       <= 2'd0;
      ref_cnt_q  <= 16'd0;
      err_q_flag <= 1'b0;
      err_q      <= ERR_NONE;
      rd_pend    <= 1'b0;
      pv         <= 2'b00;
    end else begin
      for (int i = 0; i < 4; i++)
        if (banks[i].stamp != TRCD_V)
          banks[i].stamp <= banks[i].stamp + 4'd1;
      if (ref_age != TRC_V)
        ref_age <= ref_age + 8'd1;

      rd_pend <= is_rd & cur.open;
      pv[0]   <= rd_pend;
      pd[0]   <= rdata;
      pv[1]   <= pv[0];
      pd[1]   <= pd[0];

      case (cmd)
        CMD_ACT: begin
          banks[SDRAM_BA].open  <= 1'b1;
          banks[SDRAM_BA].row   <= SDRAM_A;
          banks[SDRAM_BA].stamp <= 4'd1;
        end
        CMD_RD, CMD_WR: begin
          if (cur.open && SDRAM_A[A_AUTO_PRE])
            banks[SDRAM_BA].open <= 1'b0;
        end
        CMD_PRE: begin
          if (SDRAM_A[A_AUTO_PRE])
            for (int i = 0; i < 4; i++)
              banks[i].open <= 1'b0;
          else
            banks[SDRAM_BA].open <= 1'b0;
        end
        CMD_REF: begin
          ref_cnt_q <= ref_cnt_q + 16'd1;
          ref_age   <= 8'd1;
        end
        CMD_LMR: begin
          if (mode_sup) begin
            mode_q <= 1'b1;
            cl_q   <= SDRAM_A[MODE_CL_LSB +: 2];
          end
        end
        default: ;
      endcase

      if (err_now != ERR_NONE) begin
        err_q_flag <= 1'b1;
        if (!err_q_flag) err_q <= err_now;
      end
    end
  end

  always_comb begin
    drv  = 1'b0;
    dout = pd[1];
    if (cl_q == 2'd2) begin
      drv  = pv[0];
      dout = pd[0];
    end else if (cl_q == 2'd3) begin
      drv  = pv[1];
    end
  end

  assign SDRAM_DQ    = drv ? dout : 16'hzzzz;
  assign mode_valid  = mode_q;
  assign cas_lat     = cl_q;
  assign refresh_cnt = ref_cnt_q;
  assign proto_err   = err_q_flag;
  assign err_code    = err_q;

endmodule
